// File: rtl/seq_div_64by32_if.sv
// Divider request/response bundle: request side (iValid/iReady/iN/iD), result side (oValid/oReady/oQ/oR/oDivZero).
// Latency and backpressure are defined by the divider; this file only carries the wires.
interface seq_div_64by32_if #(
  parameter int wI = 32,
  parameter int wO = 2*wI
);
  logic          iValid;
  logic          iReady;
  logic [wO-1:0] iN;
  logic [wI-1:0] iD;
  logic          oValid;
  logic          oReady;
  logic [wO-1:0] oQ;
  logic [wI-1:0] oR;
  logic          oDivZero;

  modport slave (
    input  iValid, iN, iD, oReady,
    output iReady, oValid, oQ, oR, oDivZero
  );

  modport master (
    output iValid, iN, iD, oReady,
    input  iReady, oValid, oQ, oR, oDivZero
  );
endinterface

// File: rtl/seq_div_64by32.sv
// Radix-2 restoring divider, wO/wI -> wO quotient + wI remainder; wO+1 cycles accept-to-valid (1 for D=0).
// Backpressure: single operation in flight; iReady low until the result is taken, result held while oReady=0.
module seq_div_64by32 #(
  parameter int wI = 32,
  parameter int wO = 2*wI
) (
  input logic           clk,
  input logic           rst,
  seq_div_64by32_if.slave bus
);

  localparam int CW = $clog2(wO);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nstate;

  logic [wI:0]   r_rem;
  logic [wO-1:0] r_q;
  logic [wI-1:0] r_d;
  logic [CW-1:0] r_cnt;
  logic [wO-1:0] r_oq;
  logic [wI-1:0] r_or;
  logic          r_odz;

  logic [wI:0]   w_t;
  logic [wI:0]   w_diff;
  logic          w_ge;
  logic [wI:0]   w_rem_nxt;
  logic [wO-1:0] w_q_nxt;
  logic          w_dz;
  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic          w_release;

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  assign w_t       = {r_rem[wI-1:0], r_q[wO-1]};
  assign w_ge      = (w_t >= {1'b0, r_d});
  assign w_diff    = w_t - {1'b0, r_d};
  assign w_rem_nxt = w_ge ? w_diff : w_t;
  assign w_q_nxt   = {r_q[wO-2:0], w_ge};
  assign w_dz      = (bus.iD == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE: begin
        if (bus.iValid) begin
          w_nstate = w_dz ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_nstate = DONE;
        end
      end
      DONE: begin
        if (bus.oReady) begin
          w_nstate = IDLE;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so there is no input-to-output path.
  always_comb begin
    bus.iReady = 1'b0;
    bus.oValid = 1'b0;
    w_accept   = 1'b0;
    w_step     = 1'b0;
    w_last     = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.iReady = 1'b1;
        w_accept   = bus.iValid;
      end
      BUSY: begin
        w_step = 1'b1;
        w_last = (r_cnt == '0);
      end
      DONE: begin
        bus.oValid = 1'b1;
        w_release  = bus.oReady;
      end
      default: begin
        bus.iReady = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_q   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_oq  <= '0;
      r_or  <= '0;
      r_odz <= 1'b0;
    end else if (w_accept) begin
      r_d   <= bus.iD;
      r_q   <= bus.iN;
      r_rem <= '0;
      r_cnt <= CW'(wO-1);
      if (w_dz) begin
        r_oq  <= '1;
        r_or  <= bus.iN[wI-1:0];
        r_odz <= 1'b1;
      end
    end else if (w_step) begin
      r_q   <= w_q_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_oq  <= w_q_nxt;
        r_or  <= w_rem_nxt[wI-1:0];
        r_odz <= 1'b0;
      end
    end
  end

  assign bus.oQ       = r_oq;
  assign bus.oR       = r_or;
  assign bus.oDivZero = r_odz;

  // Partial remainder must stay below the divisor, which keeps its top bit clear.
  a_rem_bound: assert property (@(posedge clk) disable iff (rst)
    w_step |-> (w_rem_nxt[wI] == 1'b0) && (w_rem_nxt[wI-1:0] < r_d));

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.oValid && !bus.oReady) |=> (bus.oValid && $stable(r_oq) && $stable(r_or) && $stable(r_odz)));

  logic w_unused;
  assign w_unused = w_release;

endmodule

// File: tb/tb_seq_div_64by32.sv
// Directed bench for seq_div_64by32: reset, latency, extremes, divide-by-zero, backpressure, mid-op reset, random a*b+c.
module tb_seq_div_64by32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_div_64by32_if #(.wI(32), .wO(64)) bus();

  seq_div_64by32 #(.wI(32), .wO(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk1({tag, "_iready"}, bus.iReady, 1'b1);
    chk1({tag, "_ovalid"}, bus.oValid, 1'b0);
    chk64({tag, "_oq"}, bus.oQ, 64'd0);
    chk64({tag, "_or"}, {32'd0, bus.oR}, 64'd0);
    chk1({tag, "_odz"}, bus.oDivZero, 1'b0);
  endtask

  // Leaves the bench at the negedge of the first cycle after the accept edge.
  task automatic send(input logic [63:0] n, input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.iValid = 1'b1;
    bus.iN     = n;
    bus.iD     = d;
    while (bus.iReady !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk1("send_iready", bus.iReady, 1'b1);
    @(negedge clk);
    bus.iValid = 1'b0;
    bus.iN     = {$urandom, $urandom};
    bus.iD     = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.oValid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_chk(input string tag);
    bus.oReady = 1'b1;
    @(negedge clk);
    bus.oReady = 1'b0;
    chk1({tag, "_rel_iready"}, bus.iReady, 1'b1);
    chk1({tag, "_rel_ovalid"}, bus.oValid, 1'b0);
  endtask

  task automatic run(input string tag, input logic [63:0] n, input logic [31:0] d,
                     input logic [63:0] eq, input logic [31:0] er, input logic edz, input int elat);
    int lat;
    send(n, d);
    wait_done(lat);
    chk64({tag, "_lat"}, 64'(lat), 64'(elat));
    chk64({tag, "_q"}, bus.oQ, eq);
    chk64({tag, "_r"}, {32'd0, bus.oR}, {32'd0, er});
    chk1({tag, "_dz"}, bus.oDivZero, edz);
    release_chk(tag);
  endtask

  initial begin
    int lat;
    int seen;
    int guard;
    logic rdy;
    logic [31:0] a, b, c;
    logic [63:0] n;

    rst        = 1'b1;
    bus.iValid = 1'b0;
    bus.iN     = '0;
    bus.iD     = '0;
    bus.oReady = 1'b0;

    do_reset("rst_idle");

    send(64'd100, 32'd7);
    repeat (10) @(negedge clk);
    do_reset("rst_busy");
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.oValid === 1'b1) seen++;
    end
    chk64("rst_busy_no_result", 64'(seen), 64'd0);

    send(64'd5, 32'd0);
    chk1("pre_rst_done_ovalid", bus.oValid, 1'b1);
    do_reset("rst_done");

    run("small", 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, 65);
    run("ext_max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 32'd0, 1'b0, 65);
    run("ext_pow2", 64'h0000_0001_0000_0000, 32'h10, 64'h1000_0000, 32'd0, 1'b0, 65);
    run("ext_small", 64'd5, 32'd9, 64'd0, 32'd5, 1'b0, 65);
    run("divzero", 64'h1234_5678_9ABC_DEF0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1);

    // Result held under backpressure while the request side is toggled.
    send(64'd12345, 32'd10);
    wait_done(lat);
    chk64("bp_lat", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      bus.iValid = ~bus.iValid;
      bus.iN     = {$urandom, $urandom};
      bus.iD     = $urandom;
      @(negedge clk);
      chk1("bp_ovalid", bus.oValid, 1'b1);
      chk1("bp_iready", bus.iReady, 1'b0);
      chk64("bp_q", bus.oQ, 64'd1234);
      chk64("bp_r", {32'd0, bus.oR}, 64'd5);
      chk1("bp_dz", bus.oDivZero, 1'b0);
    end
    bus.iValid = 1'b0;
    release_chk("bp");

    send(64'd777, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.oValid === 1'b1) seen++;
    end
    chk64("midrst_no_result", 64'(seen), 64'd0);
    run("post_rst", 64'd1000, 32'd3, 64'd333, 32'd1, 1'b0, 65);

    for (int k = 0; k < 8; k++) begin
      a = $urandom;
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      c = $urandom % b;
      n = {32'd0, a} * {32'd0, b} + {32'd0, c};
      bus.oReady = 1'($urandom % 2);
      send(n, b);
      wait_done(lat);
      chk64("rnd_lat", 64'(lat), 64'd65);
      guard = 0;
      rdy   = 1'b0;
      while (!rdy && guard < 50) begin
        chk1("rnd_ovalid", bus.oValid, 1'b1);
        chk64("rnd_q", bus.oQ, {32'd0, a});
        chk64("rnd_r", {32'd0, bus.oR}, {32'd0, c});
        rdy = (guard == 20) ? 1'b1 : 1'($urandom % 2);
        bus.oReady = rdy;
        @(negedge clk);
        guard++;
      end
      bus.oReady = 1'b0;
      chk1("rnd_rel_ovalid", bus.oValid, 1'b0);
      chk1("rnd_rel_iready", bus.iReady, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
